// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle control unit for the Lapido datapath. Each instruction is walked
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. The unit decodes
//   the class field instruction[31:29] and the operation field
//   instruction[28:24]. It drives the datapath strobes and flags illegal
//   encodings and memory timeouts with a one-cycle pulse. Every output is
//   registered and changes on the edge that enters the state it belongs to.
//
// Optional feature:
//   CONTROL_BRANCH_EN - class 110 decodes as beq/bne. When it is undefined,
//                       class 110 is illegal and branch is tied low.
//
// Ports:
//   clock        in   system clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   instruction  in   instruction word; sampled only in FETCH
//   instr_valid  in   instruction present; sampled only in FETCH
//   mem_ready    in   data memory has completed the access
//   zero         in   ALU zero flag (branch feature only)
//   branch       out  take branch
//   memRead      out  memory read strobe, active-low
//   memWrite     out  memory write strobe, active-low
//   memToReg     out  select memory data for write-back
//   ALUOp        out  ALU operation
//   ALUSrc       out  1 = immediate operand, 0 = register operand
//   regWrite     out  register file write enable
//   enablePC     out  one-cycle PC advance pulse
//   irWrite      out  one-cycle instruction-register load pulse
//   illegal      out  one-cycle illegal / timeout pulse
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int INSTR_WIDTH = 32,
    parameter int ALUOP_WIDTH = 5,
    parameter int NUM_ALU_OPS = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int ALUOP_SUB   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    input  logic                   mem_ready,
    input  logic                   zero,
    output logic                   branch,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   memToReg,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   ALUSrc,
    output logic                   regWrite,
    output logic                   enablePC,
    output logic                   irWrite,
    output logic                   illegal
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [2:0] CLS_ALU = 3'b001;
    localparam logic [2:0] CLS_LIT = 3'b010;
    localparam logic [2:0] CLS_MEM = 3'b100;
    localparam logic [2:0] CLS_BR  = 3'b110;
    localparam int         CNT_W   = $clog2(MEM_TIMEOUT + 1);

    state_t                 r_state,      w_nxt_state;
    logic [7:0]             r_ir,         w_nxt_ir;       // latched instruction[31:24]
    logic [CNT_W-1:0]       r_wait_cnt,   w_nxt_wait_cnt;
    logic                   r_mem_read,   w_nxt_mem_read;
    logic                   r_mem_write,  w_nxt_mem_write;
    logic                   r_mem_to_reg, w_nxt_mem_to_reg;
    logic [ALUOP_WIDTH-1:0] r_aluop,      w_nxt_aluop;
    logic                   r_alusrc,     w_nxt_alusrc;
    logic                   r_reg_write,  w_nxt_reg_write;
    logic                   r_enable_pc,  w_nxt_enable_pc;
    logic                   r_ir_write,   w_nxt_ir_write;
    logic                   r_illegal,    w_nxt_illegal;
`ifdef CONTROL_BRANCH_EN
    logic                   r_branch,     w_nxt_branch;
`endif

    logic [2:0]             w_cls;
    logic [4:0]             w_op;
    logic                   w_is_store;
    logic                   w_is_lit;
    logic                   w_op_legal;
    logic                   w_decode_ok;
    logic [CNT_W-1:0]       w_wait_inc;
    logic                   w_unused;

    // Decode always looks at the latched copy, never the live instruction bus.
    assign w_cls      = r_ir[7:5];
    assign w_op       = r_ir[4:0];
    assign w_is_store = r_ir[0];
    assign w_is_lit   = (r_ir[1:0] == 2'b10);
    assign w_op_legal = ({27'd0, w_op} < 32'(NUM_ALU_OPS));
    assign w_wait_inc = r_wait_cnt + CNT_W'(1);

    // Only instruction[31:24] is decoded; zero matters only for branches.
    assign w_unused   = ^{instruction, zero};

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_ir         = r_ir;
        w_nxt_wait_cnt   = '0;
        w_nxt_mem_read   = 1'b1;
        w_nxt_mem_write  = 1'b1;
        w_nxt_mem_to_reg = 1'b0;
        w_nxt_aluop      = r_aluop;
        w_nxt_alusrc     = r_alusrc;
        w_nxt_reg_write  = 1'b0;
        w_nxt_enable_pc  = 1'b0;
        w_nxt_ir_write   = 1'b0;
        w_nxt_illegal    = 1'b0;
        w_decode_ok      = 1'b0;
`ifdef CONTROL_BRANCH_EN
        w_nxt_branch     = 1'b0;
`endif

        case (r_state)
            S_FETCH: begin
                if (instr_valid) begin
                    w_nxt_ir       = instruction[31:24];
                    w_nxt_ir_write = 1'b1;
                    w_nxt_state    = S_DECODE;
                end
            end

            S_DECODE: begin
                case (w_cls)
                    CLS_ALU: begin
                        if (w_op_legal) begin
                            w_decode_ok  = 1'b1;
                            w_nxt_aluop  = ALUOP_WIDTH'(w_op);
                            w_nxt_alusrc = 1'b0;
                        end
                    end
                    CLS_MEM: begin
                        w_decode_ok  = 1'b1;
                        w_nxt_aluop  = '0;
                        w_nxt_alusrc = 1'b1;
                    end
                    CLS_LIT: begin
                        if (w_is_lit) begin
                            w_decode_ok  = 1'b1;
                            w_nxt_aluop  = '0;
                            w_nxt_alusrc = 1'b1;
                        end
                    end
`ifdef CONTROL_BRANCH_EN
                    CLS_BR: begin
                        w_decode_ok  = 1'b1;
                        w_nxt_aluop  = ALUOP_WIDTH'(ALUOP_SUB);
                        w_nxt_alusrc = 1'b0;
                    end
`endif
                    default: ;
                endcase

                if (w_decode_ok) begin
                    w_nxt_state = S_EXEC;
                end else begin
                    w_nxt_state     = S_FETCH;
                    w_nxt_illegal   = 1'b1;
                    w_nxt_enable_pc = 1'b1;
                end
            end

            S_EXEC: begin
                case (w_cls)
                    CLS_MEM: begin
                        w_nxt_state = S_MEM;
                        if (w_is_store) w_nxt_mem_write = 1'b0;
                        else            w_nxt_mem_read  = 1'b0;
                    end
`ifdef CONTROL_BRANCH_EN
                    CLS_BR: begin
                        // bit24 = 0: beq, bit24 = 1: bne
                        w_nxt_state     = S_FETCH;
                        w_nxt_enable_pc = 1'b1;
                        w_nxt_branch    = w_is_store ? ~zero : zero;
                    end
`endif
                    default: begin
                        // ALU and loadlit go straight to write-back.
                        w_nxt_state     = S_WB;
                        w_nxt_reg_write = 1'b1;
                        w_nxt_enable_pc = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                // Completion is tested first so a ready on the last allowed
                // cycle still finishes the access instead of timing out.
                if (mem_ready) begin
                    w_nxt_enable_pc = 1'b1;
                    if (w_is_store) begin
                        w_nxt_state = S_FETCH;
                    end else begin
                        w_nxt_state      = S_WB;
                        w_nxt_reg_write  = 1'b1;
                        w_nxt_mem_to_reg = 1'b1;
                    end
                end else if (w_wait_inc == CNT_W'(MEM_TIMEOUT)) begin
                    w_nxt_state     = S_FETCH;
                    w_nxt_illegal   = 1'b1;
                    w_nxt_enable_pc = 1'b1;
                end else begin
                    w_nxt_wait_cnt = w_wait_inc;
                    if (w_is_store) w_nxt_mem_write = 1'b0;
                    else            w_nxt_mem_read  = 1'b0;
                end
            end

            S_WB: begin
                w_nxt_state = S_FETCH;
            end

            default: begin
                w_nxt_state = S_FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_wait_cnt   <= '0;
            r_mem_read   <= 1'b1;
            r_mem_write  <= 1'b1;
            r_mem_to_reg <= 1'b0;
            r_aluop      <= '0;
            r_alusrc     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_enable_pc  <= 1'b0;
            r_ir_write   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_ir         <= w_nxt_ir;
            r_wait_cnt   <= w_nxt_wait_cnt;
            r_mem_read   <= w_nxt_mem_read;
            r_mem_write  <= w_nxt_mem_write;
            r_mem_to_reg <= w_nxt_mem_to_reg;
            r_aluop      <= w_nxt_aluop;
            r_alusrc     <= w_nxt_alusrc;
            r_reg_write  <= w_nxt_reg_write;
            r_enable_pc  <= w_nxt_enable_pc;
            r_ir_write   <= w_nxt_ir_write;
            r_illegal    <= w_nxt_illegal;
        end
    end

`ifdef CONTROL_BRANCH_EN
    always_ff @(posedge clock) begin
        if (reset) r_branch <= 1'b0;
        else       r_branch <= w_nxt_branch;
    end
    assign branch = r_branch;
`else
    assign branch = 1'b0;
`endif

    assign memRead  = r_mem_read;
    assign memWrite = r_mem_write;
    assign memToReg = r_mem_to_reg;
    assign ALUOp    = r_aluop;
    assign ALUSrc   = r_alusrc;
    assign regWrite = r_reg_write;
    assign enablePC = r_enable_pc;
    assign irWrite  = r_ir_write;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. A transaction-level model turns each
//   instruction into the list of output vectors expected after every edge,
//   from the accept edge until the unit is back in FETCH. One compare process
//   checks the DUT against that list on every cycle. Literal per-instruction
//   figures (cycle counts, strobe-low counts) pin the model.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int T_OUT = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        mem_ready;
    logic        zero;
    logic        branch, memRead, memWrite, memToReg, ALUSrc;
    logic        regWrite, enablePC, irWrite, illegal;
    logic [4:0]  ALUOp;

    always #5 clock = ~clock;

    multicycle_control #(
        .INSTR_WIDTH(32), .ALUOP_WIDTH(5), .NUM_ALU_OPS(16),
        .MEM_TIMEOUT(T_OUT), .ALUOP_SUB(1)
    ) dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .instr_valid(instr_valid), .mem_ready(mem_ready), .zero(zero),
        .branch(branch), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .regWrite(regWrite), .enablePC(enablePC), .irWrite(irWrite),
        .illegal(illegal)
    );

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [4:0] aluop;
        logic       alusrc;
        logic       reg_write;
        logic       enable_pc;
        logic       ir_write;
        logic       illegal;
    } outs_t;

    localparam outs_t RESET_VEC = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    outs_t dut_outs;
    assign dut_outs = '{branch, memRead, memWrite, memToReg, ALUOp, ALUSrc,
                        regWrite, enablePC, irWrite, illegal};

    int    checks = 0;
    int    errors = 0;
    outs_t exp_cur;
    logic  exp_en = 1'b0;
    string exp_name;

    // Model state: ALU controls persist until the next legal decode or reset.
    logic [4:0] m_aluop  = 5'd0;
    logic       m_alusrc = 1'b0;
    outs_t      trace[$];
    int         ready_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic outs_t idle();
        outs_t e;
        e        = RESET_VEC;
        e.aluop  = m_aluop;
        e.alusrc = m_alusrc;
        return e;
    endfunction

    // Expected output after each edge of one instruction. trace[0] is the
    // accept edge. ready_at = MEM cycle on which memory answers (0 = never).
    task automatic model_build(input logic [31:0] ins, input int ready_at, input logic z);
        logic [2:0] cls;
        logic [4:0] op;
        outs_t      e;
        bit         legal, is_br, done, store;
        int         m;
        cls   = ins[31:29];
        op    = ins[28:24];
        store = ins[24];
        legal = 0;
        is_br = 0;
        trace.delete();
        ready_edge = 0;

        e = idle(); e.ir_write = 1'b1; trace.push_back(e);

        if (cls == 3'b001 && op < 5'd16) begin
            legal = 1; m_aluop = op; m_alusrc = 1'b0;
        end else if (cls == 3'b100) begin
            legal = 1; m_aluop = 5'd0; m_alusrc = 1'b1;
        end else if (cls == 3'b010 && ins[25:24] == 2'b10) begin
            legal = 1; m_aluop = 5'd0; m_alusrc = 1'b1;
        end
`ifdef CONTROL_BRANCH_EN
        else if (cls == 3'b110) begin
            legal = 1; is_br = 1; m_aluop = 5'd1; m_alusrc = 1'b0;
        end
`endif

        if (!legal) begin
            e = idle(); e.illegal = 1'b1; e.enable_pc = 1'b1; trace.push_back(e);
            return;
        end
        trace.push_back(idle());

        if (is_br) begin
            e = idle(); e.enable_pc = 1'b1; e.branch = store ? ~z : z;
            trace.push_back(e);
        end else if (cls == 3'b100) begin
            done = (ready_at >= 1 && ready_at <= T_OUT);
            m    = done ? ready_at : T_OUT;
            if (done) ready_edge = 3 + ready_at;
            for (int j = 0; j < m; j++) begin
                e = idle();
                if (store) e.mem_write = 1'b0;
                else       e.mem_read  = 1'b0;
                trace.push_back(e);
            end
            e = idle(); e.enable_pc = 1'b1;
            if (!done) begin
                e.illegal = 1'b1; trace.push_back(e);
            end else if (store) begin
                trace.push_back(e);
            end else begin
                e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                trace.push_back(e); trace.push_back(idle());
            end
        end else begin
            e = idle(); e.reg_write = 1'b1; e.enable_pc = 1'b1;
            trace.push_back(e); trace.push_back(idle());
        end
    endtask

    // The single compare process: every cycle with an active expectation.
    always @(posedge clock) begin
        #1;
        if (exp_en) check(exp_name, 32'(dut_outs), 32'(exp_cur));
    end

    // Runs one instruction plus one idle FETCH cycle. After the accept edge,
    // instr_valid stays high with an illegal instruction word on the bus to
    // show both are ignored outside FETCH.
    task automatic run(input string name, input logic [31:0] ins, input int ready_at,
                       input logic z, output int n, output int rd_low, output int wr_low,
                       output int rw, output int ill, output int br);
        model_build(ins, ready_at, z);
        n = trace.size();
        rd_low = 0; wr_low = 0; rw = 0; ill = 0; br = 0;
        zero = z;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clock);
            instr_valid = (c <= n);
            instruction = (c == 1) ? ins : (32'hE000_0000 | 32'(c));
            mem_ready   = (c == ready_edge) || (c == 2);
            exp_cur     = (c <= n) ? trace[c-1] : idle();
            exp_name    = $sformatf("%s_edge%0d", name, c);
            exp_en      = 1'b1;
            @(posedge clock);
            #1;
            if (!memRead)  rd_low++;
            if (!memWrite) wr_low++;
            if (regWrite)  rw++;
            if (illegal)   ill++;
            if (branch)    br++;
        end
        @(negedge clock);
        exp_en      = 1'b0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, rd, wr, rw, ill, br;
        reset = 1'b1; instruction = '0; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", 32'(dut_outs), 32'(RESET_VEC));
        @(negedge clock);
        reset = 1'b0;

        run("add", 32'h2000_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("add_edges", n, 4);
        check("add_regwrite", rw, 1);

        run("alu_op15", 32'h2F00_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("op15_aluop", 32'(ALUOp), 15);
        check("op15_illegal", ill, 0);

        run("load_r3", 32'h8000_0000, 3, 1'b0, n, rd, wr, rw, ill, br);
        check("load_edges", n, 7);
        check("load_rd_low", rd, 3);
        check("load_regwrite", rw, 1);

        run("store_r1", 32'h8100_0000, 1, 1'b0, n, rd, wr, rw, ill, br);
        check("store_edges", n, 4);
        check("store_wr_low", wr, 1);
        check("store_regwrite", rw, 0);

        run("store_r4", 32'h8100_0000, 4, 1'b0, n, rd, wr, rw, ill, br);
        check("store4_edges", n, 7);

        run("load_timeout", 32'h8000_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("timeout_rd_low", rd, 15);
        check("timeout_illegal", ill, 1);
        check("timeout_regwrite", rw, 0);
        check("timeout_memread", 32'(memRead), 1);

        run("load_r15", 32'h8000_0000, 15, 1'b0, n, rd, wr, rw, ill, br);
        check("ready_at_limit_illegal", ill, 0);
        check("ready_at_limit_regwrite", rw, 1);

        run("illegal_E0", 32'hE000_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("illE0_edges", n, 2);
        check("illE0_pulse", ill, 1);
        check("illE0_strobes", rd + wr + rw, 0);

        run("alu_op20", 32'h3400_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("op20_pulse", ill, 1);
        run("alu_op16", 32'h3000_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("op16_pulse", ill, 1);
        run("class000", 32'h0000_0000, 0, 1'b0, n, rd, wr, rw, ill, br);

        run("loadlit", 32'h4200_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("loadlit_regwrite", rw, 1);
        check("loadlit_alusrc", 32'(ALUSrc), 1);
        run("lit_bad", 32'h4100_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("lit_bad_pulse", ill, 1);

        run("beq_z1", 32'hC000_0000, 0, 1'b1, n, rd, wr, rw, ill, br);
`ifdef CONTROL_BRANCH_EN
        check("beq_z1_branch", br, 1);
        check("beq_edges", n, 3);
`else
        check("c110_illegal", ill, 1);
        check("c110_branch", br, 0);
`endif
        run("bne_z1", 32'hC100_0000, 0, 1'b1, n, rd, wr, rw, ill, br);
        check("bne_z1_branch", br, 0);
        run("bne_z0", 32'hC100_0000, 0, 1'b0, n, rd, wr, rw, ill, br);

        // Reset while a store is waiting in MEM.
        @(negedge clock);
        instruction = 32'h8100_0000; instr_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("midop_memwrite_low", 32'(memWrite), 0);
        check("midop_alusrc", 32'(ALUSrc), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midop_reset_outputs", 32'(dut_outs), 32'(RESET_VEC));
        m_aluop = 5'd0; m_alusrc = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run("add_after_reset", 32'h2000_0000, 0, 1'b0, n, rd, wr, rw, ill, br);
        check("post_reset_edges", n, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
